// File: rtl/loopback_pkg.sv
// ----------------------------------------------------------------------------
// loopback_pkg
// Shared helpers for the loopback return-path FIFO:
//   level_width(depth) : bits needed to hold an occupancy of 0..depth
//   ptr_width(depth)   : bits of a read/write pointer into depth entries
//   PAYLOAD_RST_BIT    : reset value replicated across every payload bit
// ----------------------------------------------------------------------------
package loopback_pkg;

   localparam bit PAYLOAD_RST_BIT = 1'b0;

   function automatic int level_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/loopback_fifo_mem.sv
// ----------------------------------------------------------------------------
// loopback_fifo_mem
// DEPTH x WIDTH register array with one synchronous write port and one
// asynchronous read port.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears all entries)
//   we         : write enable
//   waddr      : write address
//   wdata      : write data
//   raddr      : read address
//   rdata      : read data (combinational from raddr)
// ----------------------------------------------------------------------------
module loopback_fifo_mem
   import loopback_pkg::*;
#(
   parameter  int WIDTH = 1,
   parameter  int DEPTH = 4,
   localparam int PW    = ptr_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [PW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [PW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // NOTE: the array is reset so an empty FIFO never presents X on its read
   // port; on a loopback, X would propagate straight back into the producer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= {WIDTH{PAYLOAD_RST_BIT}};
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/loopback_fifo.sv
// ----------------------------------------------------------------------------
// loopback_fifo
// Registered ready/valid elastic buffer for the return path of a loopback.
// in_ready and out_valid come straight from flops, so the loop through this
// block never forms a combinational path.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_data, in_valid   : producer side payload / offer
//   in_ready            : FIFO accepts this cycle (registered)
//   out_data, out_valid : head of queue / FIFO non-empty (registered)
//   out_ready           : consumer takes the head this cycle
//   level               : current occupancy, 0..DEPTH
//   peak                : highest level since reset or last peak_clr
//   peak_clr            : synchronous clear of peak (loads next level)
// ----------------------------------------------------------------------------
module loopback_fifo
   import loopback_pkg::*;
#(
   parameter  int WIDTH = 1,
   parameter  int DEPTH = 4,
   localparam int LW    = level_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [LW-1:0]    level,
   output logic [LW-1:0]    peak,
   input  logic             peak_clr
);

   localparam int            PW       = ptr_width(DEPTH);
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [LW-1:0]    level_next;
   logic [LW-1:0]    peak_next;
   logic [WIDTH-1:0] head_data;
   logic [WIDTH-1:0] last_popped;
   logic             push;
   logic             pop;

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;

   loopback_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (push),
      .waddr (wr_ptr),
      .wdata (in_data),
      .raddr (rd_ptr),
      .rdata (head_data)
   );

   // NOTE: every signal written here gets its default first, so no path
   // through the block leaves it unassigned and no latch is inferred.
   always_comb begin
      level_next = level;
      if (push && !pop) begin
         level_next = level + 1'b1;
      end else if (pop && !push) begin
         level_next = level - 1'b1;
      end
      peak_next = peak;
      if (peak_clr) begin
         peak_next = level_next;
      end else if (level_next > peak) begin
         peak_next = level_next;
      end
   end

   // NOTE: all state uses non-blocking assignments so every flop samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level       <= '0;
         peak        <= '0;
         in_ready    <= 1'b0;
         out_valid   <= 1'b0;
         last_popped <= {WIDTH{PAYLOAD_RST_BIT}};
      end else begin
         // DEPTH is a power of two, so the natural pointer overflow wraps
         // modulo DEPTH without skipping entries.
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr      <= rd_ptr + 1'b1;
            last_popped <= head_data;
         end
         level     <= level_next;
         peak      <= peak_next;
         in_ready  <= (level_next < FULL_LVL);
         out_valid <= (level_next != '0);
      end
   end

   // When empty the read pointer sits on a stale slot, so the last popped
   // value is presented instead.
   assign out_data = out_valid ? head_data : last_popped;

endmodule

// File: tb/tb_loopback_fifo.sv
module tb_loopback_fifo;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [LW-1:0]    level;
   logic [LW-1:0]    peak;
   logic             peak_clr = 1'b0;

   // Loopback wrapper instance: producer drives a constant 1, consumer
   // always ready.
   logic             w_in_ready;
   logic [0:0]       w_out_data;
   logic             w_out_valid;
   logic [LW-1:0]    w_level;
   logic [LW-1:0]    w_peak;

   int checks = 0;
   int failures = 0;

   // Behavioural model: a queue plus the registered flags.
   logic [WIDTH-1:0] m_q[$];
   logic [WIDTH-1:0] m_last = '0;
   bit               m_in_ready = 1'b0;
   int               m_peak = 0;
   bit               m_pushed = 1'b0;

   always #5 clk = ~clk;

   loopback_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .level     (level),
      .peak      (peak),
      .peak_clr  (peak_clr)
   );

   loopback_fifo #(.WIDTH(1), .DEPTH(DEPTH)) wrap (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (1'b1),
      .in_valid  (1'b1),
      .in_ready  (w_in_ready),
      .out_data  (w_out_data),
      .out_valid (w_out_valid),
      .out_ready (1'b1),
      .level     (w_level),
      .peak      (w_peak),
      .peak_clr  (1'b0)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic compare_all(input string ctx);
      logic [WIDTH-1:0] exp_data;
      exp_data = (m_q.size() > 0) ? m_q[0] : m_last;
      check({ctx, ".level"},     32'(level),     32'(m_q.size()));
      check({ctx, ".in_ready"},  32'(in_ready),  32'(m_in_ready));
      check({ctx, ".out_valid"}, 32'(out_valid), 32'(m_q.size() > 0));
      check({ctx, ".out_data"},  32'(out_data),  32'(exp_data));
      check({ctx, ".peak"},      32'(peak),      32'(m_peak));
   endtask

   task automatic model_reset();
      m_q.delete();
      m_last     = '0;
      m_in_ready = 1'b0;
      m_peak     = 0;
      m_pushed   = 1'b0;
   endtask

   // One clock edge: update the model from the inputs the DUT sampled, then
   // compare just after the edge.
   task automatic step(input string ctx);
      bit push, pop;
      @(posedge clk);
      push = in_valid && m_in_ready;
      pop  = (m_q.size() > 0) && out_ready;
      if (pop)  m_last = m_q.pop_front();
      if (push) m_q.push_back(in_data);
      m_in_ready = (m_q.size() < DEPTH);
      if (peak_clr)                m_peak = m_q.size();
      else if (m_q.size() > m_peak) m_peak = m_q.size();
      m_pushed = push;
      #1;
      compare_all(ctx);
   endtask

   initial begin
      logic [WIDTH-1:0] fill_vals[4]  = '{8'h11, 8'h22, 8'h33, 8'h44};
      logic [WIDTH-1:0] drain_exp[4]  = '{8'h22, 8'h33, 8'h44, 8'h55};

      // Reset release: producer offers data the whole time.
      model_reset();
      in_valid = 1'b1;
      in_data  = 8'h01;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("rst.in_ready", 32'(in_ready), 32'd0);
         check("rst.level",    32'(level),    32'd0);
         compare_all("rst");
      end
      rst_n = 1'b1;
      step("release");
      check("release.in_ready", 32'(in_ready), 32'd1);
      check("release.level",    32'(level),    32'd0);
      check("wrap.e1.in_ready", 32'(w_in_ready),  32'd1);
      check("wrap.e1.out_valid", 32'(w_out_valid), 32'd0);
      in_valid = 1'b0;

      // Fill to full with no consumer.
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = fill_vals[i];
         step("fill");
         check("fill.level", 32'(level), 32'(i + 1));
         check("wrap.out_valid", 32'(w_out_valid), 32'd1);
         check("wrap.out_data",  32'(w_out_data),  32'd1);
         check("wrap.level",     32'(w_level),     32'd1);
      end
      check("full.in_ready", 32'(in_ready), 32'd0);
      check("full.peak",     32'(peak),     32'd4);
      check("full.out_data", 32'(out_data), 32'h11);

      // Full, pop with 0x55 held: not accepted in the pop cycle.
      in_data   = 8'h55;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      step("fullpop");
      check("fullpop.level",    32'(level),    32'd3);
      check("fullpop.in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b0;
      step("accept55");
      check("accept55.level", 32'(level), 32'd4);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("drain.data", 32'(out_data), 32'(drain_exp[i]));
         step("drain");
      end
      check("drain.empty", 32'(out_valid), 32'd0);
      check("drain.hold",  32'(out_data),  32'h55);

      // Streaming with wrap; peak cleared on the first push.
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(i);
         peak_clr = (i == 0);
         step("stream");
         check("stream.level", 32'(level),    32'd1);
         check("stream.data",  32'(out_data), 32'(i));
      end
      peak_clr = 1'b0;
      in_valid = 1'b0;
      check("stream.peak", 32'(peak), 32'd1);
      step("stream.end");
      check("stream.hold", 32'(out_data), 32'd9);

      // peak_clr with level 2 and peak 4.
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = 8'hA0 + 8'(i);
         step("refill");
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step("pop2a");
      step("pop2b");
      out_ready = 1'b0;
      check("pre_clr.level", 32'(level), 32'd2);
      check("pre_clr.peak",  32'(peak),  32'd4);
      peak_clr = 1'b1;
      step("peak_clr");
      peak_clr = 1'b0;
      check("peak_clr.peak", 32'(peak), 32'd2);

      // Randomized traffic; producer holds data until accepted.
      in_valid = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (!in_valid || m_pushed) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
         end
         out_ready = ($urandom_range(0, 3) != 0) ? (i % 64 < 40) : 1'b0;
         peak_clr  = ($urandom_range(0, 15) == 0);
         step("rand");
      end
      peak_clr = 1'b0;

      // Mid-operation reset with contents present.
      in_valid  = 1'b1;
      in_data   = 8'h77;
      out_ready = 1'b0;
      step("pre_rst");
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("midrst.out_valid", 32'(out_valid), 32'd0);
      check("midrst.level",     32'(level),     32'd0);
      check("midrst.peak",      32'(peak),      32'd0);
      compare_all("midrst");
      in_valid = 1'b0;
      rst_n    = 1'b1;
      step("post_rst");
      for (int i = 0; i < 20; i++) begin
         if (!in_valid || m_pushed) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
         end
         out_ready = 1'($urandom_range(0, 1));
         step("rand2");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/loopback_fifo.md
# loopback_fifo

Registered ready/valid elastic buffer for the return path of a loopback. A producer's output (for example a unit whose `inner_out` is looped back to its own `inner_in`) passes through this FIFO before reaching the consumer input. The FIFO adds at least one register stage, so the loop never forms a combinational path. It also absorbs back-pressure and reports occupancy and peak occupancy for debug.

## Interface
Parameters:
- `WIDTH`, 1: payload width in bits; ≥1.
- `DEPTH`, 4: number of entries; power of two, ≥2.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_data`  in  WIDTH  payload from the producer.
- `in_valid`  in  1  producer offers `in_data` this cycle.
- `in_ready`  out  1  FIFO accepts this cycle; registered.
- `out_data`  out  WIDTH  head-of-queue payload.
- `out_valid`  out  1  FIFO is non-empty; registered.
- `out_ready`  in  1  consumer takes the head this cycle.
- `level`  out  LW  current occupancy, 0..DEPTH, where LW = clog2(DEPTH)+1.
- `peak`  out  LW  highest `level` since reset or the last clear.
- `peak_clr`  in  1  synchronous clear of `peak`.

## Operation
- Push occurs when `in_valid && in_ready`. Pop occurs when `out_valid && out_ready`.
- Storage is `DEPTH` registers addressed by write and read pointers of clog2(DEPTH) bits. Pointers wrap modulo DEPTH with no skipped entries.
- `level` update:
  - push only: `level` + 1
  - pop only: `level` − 1
  - push and pop together: unchanged
- `in_ready` next = (`level`next < DEPTH).
  - `in_ready` never depends combinationally on `out_ready`.
  - When the FIFO is full and a pop happens, no push is accepted in that same cycle. `in_ready` rises on the following edge.
- `out_valid` next = (`level`next > 0).
- `out_data` is the storage entry at the read pointer.
  - It is stable while `out_valid` is high and no pop occurs.
  - When the FIFO is empty, `out_data` holds the last popped value (0 after reset).
- `peak` next:
  - if `peak_clr`: `level`next
  - otherwise: max(`peak`, `level`next)
- Boundary behaviour:
  - Push into a full FIFO cannot occur because `in_ready` is 0 when full.
  - Pop from an empty FIFO cannot occur because `out_valid` is 0 when empty.
  - Push and pop at the same time with `level` = 1: the new entry becomes the head on the next edge, and `out_valid` stays 1.
  - Push and pop at the same time with `level` = DEPTH is not possible, since `in_ready` is 0.
- Protocol requirements on neighbours (violations are undefined but must not corrupt pointers):
  - The producer holds `in_data`/`in_valid` stable until accepted.
  - The consumer may drop `out_ready` at any time.

## Timing
- Reset values (asserted asynchronously while `rst_n` = 0):
  - pointers 0, storage 0, `level` 0, `peak` 0
  - `out_valid` 0, `out_data` 0
  - `in_ready` 0
- After reset release, `in_ready` rises at the first rising edge with `rst_n` = 1, so nothing is accepted in the reset-release cycle.
- Latency is 1 cycle: a push at edge N gives `out_valid` = 1 and the data visible after edge N. The consumer can pop at edge N+1.
- Throughput is 1 transfer per cycle whenever 0 < `level` < DEPTH.
- Reset asserted mid-operation discards all contents immediately. `out_valid` and `in_ready` drop asynchronously, and no partial transfer completes.

## Structure
- The shared package `loopback_pkg` holds:
  - a level-width helper function (clog2(DEPTH)+1)
  - a pointer-width helper function
  - the reset-value constant for payloads (all-zero)
- Sub-module `loopback_fifo_mem` is the DEPTH×WIDTH register array, with one write port (enable, address, data) and one asynchronous read port. Its storage resets asynchronously to 0.
- The top level holds the pointers, `level`, `peak` and the flags.
- An integration wrapper instantiates the producer with its output feeding `in_data`. `out_data` feeds back to the producer's input, and the wrapper ties `out_ready` = 1.

## Test plan
- **Reset release:** `rst_n` low for 3 cycles with `in_valid` = 1 and `in_data` = 1 → `in_ready` = 0 and `level` = 0 throughout; `in_ready` = 1 after the first edge with `rst_n` high; nothing is pushed before that edge.
- **Fill to full (DEPTH = 4, WIDTH = 8):** push 0x11, 0x22, 0x33, 0x44 with `out_ready` = 0 → `level` goes 1, 2, 3, 4; `in_ready` = 0 after the 4th push; `peak` = 4; `out_data` = 0x11.
- **Full, then pop with `in_valid` held at 0x55:** in the pop cycle 0x55 is not accepted; `level` = 3; next cycle `in_ready` = 1, 0x55 is accepted, `level` = 4. Draining then yields 0x22, 0x33, 0x44, 0x55.
- **Streaming with wrap:** 10 back-to-back values 0..9, `out_ready` = 1 → each value appears 1 cycle after it is pushed, in order; `level` stays 1; pointers wrap twice; `peak` = 1.
- **Loopback wrapper, WIDTH = 1:** the producer drives a constant 1 → after reset release, `out_valid` = 1 and `out_data` = 1 at the second edge; `level` stays at 1.
- **`peak_clr` and mid-operation reset:** with `level` = 2 and `peak` = 4, pulse `peak_clr` → `peak` = 2. Then pull `rst_n` low mid-stream → `out_valid`, `level` and `peak` are 0 immediately, with no clock edge.
